msrv32_pipe_stage_reg: RTL and testbench
========================================

Name: msrv32_pipe_stage_reg

Overview:
Parametrised pipeline stage register for the msrv32 core. It generalises the fixed decode-to-execute register block into a reusable stage with a valid/ready handshake, an optional two-entry skid buffer, flush (branch-taken kill) and a saturating stall counter. One instance sits between each pair of pipeline stages. The instruction bundle (rd/csr address, operands, pc, immediate, control fields) is carried as one opaque DATA_W bus.

Parameters:
DATA_W, 64, width of the carried bundle in bits (>=1)
SKID, 1, 1 = two-entry skid buffer with registered up_ready_out; 0 = single register, combinational ready
RESET_VAL, 0, value loaded into all data registers on reset (DATA_W bits)
CNT_W, 16, width of the stall counter

Ports:
clk_in  input  1  clock; all state updates on its rising edge
reset_in  input  1  synchronous, active-high reset
flush_in  input  1  kill all held beats (branch taken / trap)
up_valid_in  input  1  upstream beat valid
up_ready_out  output  1  stage can accept a beat this cycle
up_data_in  input  DATA_W  upstream bundle
down_valid_out  output  1  downstream beat valid
down_ready_in  input  1  downstream accepts
down_data_out  output  DATA_W  bundle to downstream (main register)
occ_out  output  2  number of held beats (0..2; max 1 when SKID=0)
stall_cnt_out  output  CNT_W  cycles with down_valid_out=1 and down_ready_in=0, saturating

Behaviour:
- Accept: up_valid_in && up_ready_out. Transfer: down_valid_out && down_ready_in. Both are evaluated on the same edge.
- Reset (reset_in=1 at an edge; overrides everything, including mid-stall): main_valid=0, skid_valid=0, main/skid data=RESET_VAL, stall_cnt=0.
- After reset: down_valid_out=0, down_data_out=RESET_VAL, occ_out=0, up_ready_out=1.
- Latency: an accepted beat appears on down_* on the next cycle. Sustained throughput is 1 beat/cycle with no bubbles.
- down_data_out is driven from the main register only. Beats leave in arrival order.
- SKID=1 states, encoded by (main_valid, skid_valid):
  - EMPTY: accept -> ONE, main<=in.
  - ONE: accept & transfer -> ONE, main<=in. Accept & no transfer -> FULL, skid<=in. Transfer only -> EMPTY. Neither -> hold.
  - FULL: transfer -> ONE, main<=skid. Otherwise hold.
  - up_ready_out = !skid_valid, a pure function of registered state. It is 0 only in FULL.
- SKID=0:
  - up_ready_out = !main_valid || down_ready_in (combinational).
  - Accept -> main<=in, valid=1. Transfer without accept -> valid=0.
- Flush (flush_in=1, reset_in=0):
  - Next cycle, main_valid=0 and skid_valid=0.
  - A beat accepted in the same cycle is discarded.
  - A transfer in the same cycle completes downstream as normal.
  - Data registers hold their old values.
  - up_ready_out is not masked by flush.
- Stall counter: +1 on each edge where down_valid_out=1 && down_ready_in=0. It holds at 2^CNT_W-1 (no wrap) and is cleared only by reset.
- Data registers load only on accept or skid->main move. They never load on idle cycles.
- down_valid_out never drops without a transfer, except on flush or reset.
- down_data_out stays stable while down_valid_out=1 && down_ready_in=0.

Test Plan:
- Reset: hold reset_in 2 cycles with up_valid_in=1, up_data_in=0xAAAA -> down_valid_out=0, down_data_out=RESET_VAL, occ_out=0, up_ready_out=1, stall_cnt_out=0.
- Streaming: SKID=1, down_ready_in=1, send beats 0x1..0x8 back-to-back -> down sees 0x1..0x8 on consecutive cycles, one cycle after each accept, with no bubbles and occ_out=1 throughout.
- Backpressure: SKID=1, down_ready_in=0, send 0x10, 0x11, 0x12 -> first two accepted, occ_out=2, up_ready_out=0, 0x12 held upstream, stall_cnt_out increments each cycle. Release down_ready_in -> outputs 0x10, 0x11, 0x12 in order.
- Flush: state FULL (0x20, 0x21), assert flush_in with up_valid_in=1, data 0x22 -> next cycle down_valid_out=0, occ_out=0, 0x22 dropped. Next accept of 0x23 -> output 0x23.
- SKID=0 simultaneous: main valid 0x30, down_ready_in=1, up_valid_in=1 with 0x31 -> up_ready_out=1 the same cycle, next cycle down_data_out=0x31 and valid stays 1.
- Saturation: CNT_W=4, stall 20 cycles -> stall_cnt_out stops at 15. Reset -> 0.

Source files
------------

// File: rtl/msrv32_pipe_stage_reg.sv
// msrv32_pipe_stage_reg
//   Reusable pipeline stage register that carries an opaque DATA_W bundle
//   between two msrv32 pipeline stages. It uses a valid/ready handshake and
//   has an optional two-entry skid buffer. A flush kills every held beat,
//   and a saturating counter records downstream stall cycles.
//
// Ports
//   clk_in          rising-edge clock
//   reset_in        synchronous active-high reset
//   flush_in        kill all held beats (branch taken / trap)
//   up_valid_in     upstream beat valid
//   up_ready_out    stage can accept a beat this cycle
//   up_data_in      upstream bundle
//   down_valid_out  downstream beat valid
//   down_ready_in   downstream accepts
//   down_data_out   bundle to downstream (main register)
//   occ_out         number of held beats (0..2)
//   stall_cnt_out   saturating count of valid-but-not-ready cycles

module msrv32_pipe_stage_reg #(
    parameter int unsigned              DATA_W    = 64,
    parameter bit                       SKID      = 1'b1,
    parameter logic [DATA_W-1:0]        RESET_VAL = '0,
    parameter int unsigned              CNT_W     = 16
) (
    input  logic              clk_in,
    input  logic              reset_in,
    input  logic              flush_in,
    input  logic              up_valid_in,
    output logic              up_ready_out,
    input  logic [DATA_W-1:0] up_data_in,
    output logic              down_valid_out,
    input  logic              down_ready_in,
    output logic [DATA_W-1:0] down_data_out,
    output logic [1:0]        occ_out,
    output logic [CNT_W-1:0]  stall_cnt_out
);

    // The state encoding is {main_valid, skid_valid}.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_ONE   = 2'b10,
        ST_FULL  = 2'b11
    } state_t;

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   main_q, main_d;
    logic [DATA_W-1:0]   skid_q, skid_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;

    logic main_valid;
    logic skid_valid;
    logic accept;
    logic xfer;

    assign main_valid = state_q[1];
    assign skid_valid = state_q[0];

    // With the skid buffer, ready comes from registers only. Without it,
    // ready looks through to downstream so a full stage can refill on the
    // same edge that it drains.
    assign up_ready_out = SKID ? !skid_valid : (!main_valid || down_ready_in);

    assign accept = up_valid_in && up_ready_out;
    assign xfer   = main_valid && down_ready_in;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;

        unique case (state_q)
            ST_EMPTY: begin
                if (accept) begin
                    state_d = ST_ONE;
                    main_d  = up_data_in;
                end
            end
            ST_ONE: begin
                if (accept && xfer) begin
                    main_d = up_data_in;
                end else if (accept && SKID) begin
                    state_d = ST_FULL;
                    skid_d  = up_data_in;
                end else if (xfer) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (xfer) begin
                    state_d = ST_ONE;
                    main_d  = skid_q;
                end
            end
            default: state_d = ST_EMPTY;
        endcase

        // A flush drops the valid bits only. Any same-cycle accept is
        // discarded, and the data registers keep their old contents.
        if (flush_in) begin
            state_d = ST_EMPTY;
            main_d  = main_q;
            skid_d  = skid_q;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (main_valid && !down_ready_in && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            state_q <= ST_EMPTY;
            main_q  <= RESET_VAL;
            skid_q  <= RESET_VAL;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
            cnt_q   <= cnt_d;
        end
    end

    assign down_valid_out = main_valid;
    assign down_data_out  = main_q;
    assign occ_out        = {1'b0, main_valid} + {1'b0, skid_valid};
    assign stall_cnt_out  = cnt_q;

endmodule

// File: tb/tb_msrv32_pipe_stage_reg.sv
module tb_msrv32_pipe_stage_reg;

    logic clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    // Instance A: SKID=1, 16-bit bundle, non-zero reset value
    logic        a_reset, a_flush, a_up_valid, a_up_ready, a_down_valid, a_down_ready;
    logic [15:0] a_up_data, a_down_data, a_cnt;
    logic [1:0]  a_occ;

    // Instance B: SKID=0, 4-bit stall counter
    logic        b_reset, b_flush, b_up_valid, b_up_ready, b_down_valid, b_down_ready;
    logic [15:0] b_up_data, b_down_data;
    logic [3:0]  b_cnt;
    logic [1:0]  b_occ;

    msrv32_pipe_stage_reg #(
        .DATA_W(16), .SKID(1'b1), .RESET_VAL(16'h5A5A), .CNT_W(16)
    ) u_a (
        .clk_in(clk_in), .reset_in(a_reset), .flush_in(a_flush),
        .up_valid_in(a_up_valid), .up_ready_out(a_up_ready), .up_data_in(a_up_data),
        .down_valid_out(a_down_valid), .down_ready_in(a_down_ready),
        .down_data_out(a_down_data), .occ_out(a_occ), .stall_cnt_out(a_cnt)
    );

    msrv32_pipe_stage_reg #(
        .DATA_W(16), .SKID(1'b0), .RESET_VAL(16'h0000), .CNT_W(4)
    ) u_b (
        .clk_in(clk_in), .reset_in(b_reset), .flush_in(b_flush),
        .up_valid_in(b_up_valid), .up_ready_out(b_up_ready), .up_data_in(b_up_data),
        .down_valid_out(b_down_valid), .down_ready_in(b_down_ready),
        .down_data_out(b_down_data), .occ_out(b_occ), .stall_cnt_out(b_cnt)
    );

    int unsigned vectors     = 0;
    int unsigned miscompares = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one edge, then settle 1 time unit past it.
    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    initial begin
        a_reset = 1'b1; a_flush = 1'b0; a_up_valid = 1'b1; a_up_data = 16'hAAAA; a_down_ready = 1'b0;
        b_reset = 1'b1; b_flush = 1'b0; b_up_valid = 1'b1; b_up_data = 16'hAAAA; b_down_ready = 1'b0;

        // ---- Reset ----
        tick(); tick();
        chk("a_rst_valid", a_down_valid, 0);
        chk("a_rst_data",  a_down_data, 16'h5A5A);
        chk("a_rst_occ",   a_occ, 0);
        chk("a_rst_ready", a_up_ready, 1);
        chk("a_rst_cnt",   a_cnt, 0);
        chk("b_rst_valid", b_down_valid, 0);
        chk("b_rst_data",  b_down_data, 16'h0000);
        chk("b_rst_cnt",   b_cnt, 0);
        a_reset = 1'b0; a_up_valid = 1'b0;
        b_reset = 1'b0; b_up_valid = 1'b0;
        tick();

        // ---- Streaming (A) ----
        a_down_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            a_up_valid = 1'b1; a_up_data = 16'(i);
            #1;
            chk("a_stream_ready", a_up_ready, 1);
            tick();
            chk("a_stream_valid", a_down_valid, 1);
            chk("a_stream_data",  a_down_data, 32'(i));
            chk("a_stream_occ",   a_occ, 1);
        end
        a_up_valid = 1'b0;
        tick();
        chk("a_stream_drain_valid", a_down_valid, 0);
        chk("a_stream_drain_occ",   a_occ, 0);

        // ---- Backpressure (A) ----
        a_down_ready = 1'b0;
        a_up_valid = 1'b1; a_up_data = 16'h0010;
        tick();
        chk("a_bp1_data", a_down_data, 16'h0010);
        chk("a_bp1_cnt",  a_cnt, 0);
        a_up_data = 16'h0011;
        tick();
        chk("a_bp2_occ",   a_occ, 2);
        chk("a_bp2_ready", a_up_ready, 0);
        chk("a_bp2_data",  a_down_data, 16'h0010);
        chk("a_bp2_cnt",   a_cnt, 1);
        a_up_data = 16'h0012;
        tick();
        chk("a_bp3_occ",  a_occ, 2);
        chk("a_bp3_data", a_down_data, 16'h0010);
        chk("a_bp3_cnt",  a_cnt, 2);
        tick();
        chk("a_bp4_cnt",  a_cnt, 3);
        a_down_ready = 1'b1;
        tick();
        chk("a_rel1_data", a_down_data, 16'h0011);
        chk("a_rel1_occ",  a_occ, 1);
        chk("a_rel1_cnt",  a_cnt, 3);
        tick();
        chk("a_rel2_data",  a_down_data, 16'h0012);
        chk("a_rel2_valid", a_down_valid, 1);
        a_up_valid = 1'b0;
        tick();
        chk("a_rel3_valid", a_down_valid, 0);
        chk("a_rel3_occ",   a_occ, 0);

        // ---- Flush from FULL (A) ----
        a_down_ready = 1'b0;
        a_up_valid = 1'b1; a_up_data = 16'h0020;
        tick();
        a_up_data = 16'h0021;
        tick();
        chk("a_fl_full_occ", a_occ, 2);
        chk("a_fl_full_cnt", a_cnt, 4);
        a_flush = 1'b1; a_up_data = 16'h0022;
        tick();
        chk("a_fl_valid", a_down_valid, 0);
        chk("a_fl_occ",   a_occ, 0);
        chk("a_fl_ready", a_up_ready, 1);
        chk("a_fl_hold",  a_down_data, 16'h0020);
        chk("a_fl_cnt",   a_cnt, 5);
        a_flush = 1'b0; a_up_data = 16'h0023;
        tick();
        chk("a_fl_next_valid", a_down_valid, 1);
        chk("a_fl_next_data",  a_down_data, 16'h0023);
        chk("a_fl_next_cnt",   a_cnt, 5);
        // Flush while a beat is both accepted and transferred: new beat dropped
        a_down_ready = 1'b1; a_up_data = 16'h0024; a_flush = 1'b1;
        tick();
        chk("a_fl2_valid", a_down_valid, 0);
        chk("a_fl2_data",  a_down_data, 16'h0023);
        a_flush = 1'b0; a_up_valid = 1'b0;
        tick();
        chk("a_fl2_idle_occ", a_occ, 0);

        // ---- SKID=0 simultaneous accept/transfer (B) ----
        b_up_valid = 1'b1; b_up_data = 16'h0030; b_down_ready = 1'b0;
        tick();
        chk("b_s0_valid", b_down_valid, 1);
        chk("b_s0_data",  b_down_data, 16'h0030);
        b_up_data = 16'h0031;
        #1;
        chk("b_s0_ready_blocked", b_up_ready, 0);
        b_down_ready = 1'b1;
        #1;
        chk("b_s0_ready_comb", b_up_ready, 1);
        tick();
        chk("b_s0_next_data",  b_down_data, 16'h0031);
        chk("b_s0_next_valid", b_down_valid, 1);
        chk("b_s0_next_occ",   b_occ, 1);
        b_up_valid = 1'b0;
        tick();
        chk("b_s0_drain_valid", b_down_valid, 0);
        chk("b_s0_cnt", b_cnt, 0);

        // ---- Saturation (B, CNT_W=4) ----
        b_down_ready = 1'b0; b_up_valid = 1'b1; b_up_data = 16'h0040;
        tick();
        b_up_valid = 1'b0;
        for (int i = 0; i < 20; i++) tick();
        chk("b_sat_cnt",   b_cnt, 15);
        chk("b_sat_valid", b_down_valid, 1);
        chk("b_sat_data",  b_down_data, 16'h0040);
        b_reset = 1'b1;
        tick();
        chk("b_sat_rst_cnt",   b_cnt, 0);
        chk("b_sat_rst_valid", b_down_valid, 0);
        b_reset = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
